// File: rtl/iicmb_pkg.sv
// Shared constants for the IICMB Wishbone sequencer.
//   - IICMB register addresses (CSR/DPR/CMDR/FSMR)
//   - CMDR command codes and CMDR status bit positions
//   - CSR value that enables the core with interrupts
//   - transaction status encoding reported on done
package iicmb_pkg;

    localparam logic [1:0] REG_CSR  = 2'd0;
    localparam logic [1:0] REG_DPR  = 2'd1;
    localparam logic [1:0] REG_CMDR = 2'd2;
    localparam logic [1:0] REG_FSMR = 2'd3;

    localparam logic [2:0] CMD_WRITE    = 3'b001;
    localparam logic [2:0] CMD_READ_ACK = 3'b010;
    localparam logic [2:0] CMD_READ_NAK = 3'b011;
    localparam logic [2:0] CMD_START    = 3'b100;
    localparam logic [2:0] CMD_STOP     = 3'b101;
    localparam logic [2:0] CMD_SET_BUS  = 3'b110;

    localparam int CMDR_DON = 7;
    localparam int CMDR_NAK = 6;
    localparam int CMDR_AL  = 5;
    localparam int CMDR_ERR = 4;

    localparam logic [7:0] CSR_ENABLE = 8'hC0;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_NAK = 2'b01,
        ST_AL  = 2'b10,
        ST_ERR = 2'b11
    } status_t;

endpackage

// File: rtl/iicmb_wb_sequencer_wb_master_access.sv
// wb_master_access: performs one Wishbone classic access per go_i pulse.
//   go_i/we_i/adr_i/wdata_i : access request (sampled while idle)
//   busy_o                  : access in progress (cyc/stb asserted)
//   done_o                  : one-cycle pulse after the ack; rdata_o valid
//   cyc_o/stb_o/we_o/adr_o/dat_o, dat_i, ack_i : Wishbone master port
// All bus outputs are registered and drop to zero on the edge after ack,
// so the cycle carrying done_o is always a bus-idle cycle.
module wb_master_access #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  go_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i
);

    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        if (cyc_q) begin
            if (ack_i) begin
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                adr_d   = '0;
                dat_d   = '0;
                rdata_d = dat_i;
                done_d  = 1'b1;
            end
        end else if (go_i) begin
            cyc_d = 1'b1;
            we_d  = we_i;
            adr_d = adr_i;
            dat_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;
    assign we_o    = we_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;
    assign busy_o  = cyc_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/iicmb_wb_sequencer.sv
// iicmb_wb_sequencer: Wishbone master that drives an IICMB I2C controller.
// Initialises the core, then turns each request into the command chain
// START, ADDR, data bytes, STOP, waiting on irq_i after every command.
//   req_*      : transaction request (rw, 7-bit address, byte count)
//   wdata_*    : write byte stream, one byte consumed per wdata_ready_o
//   rdata_*    : read bytes, one pulse each, no backpressure
//   done_o     : end-of-transaction pulse with status_o
//   cyc/stb/we/adr/dat_o, dat_i, ack_i, irq_i : IICMB Wishbone slave side
//
// state      | meaning
// INIT_CSR   | write CSR = enable + interrupt enable
// INIT_DPR   | write DPR = bus number
// INIT_CMD   | write CMDR = Set Bus
// IDLE       | ready for a request
// START      | write CMDR = Start
// ADDR_DPR   | write DPR = {address, rw}
// ADDR_CMD   | write CMDR = Write (address byte)
// WR_GET     | wait for a write byte from the stream
// WR_DPR     | write DPR = data byte
// WR_CMD     | write CMDR = Write
// RD_CMD     | write CMDR = Read+ACK, or Read+NAK for the last byte
// RD_DPR     | read DPR, emit read byte
// STOP       | write CMDR = Stop
// CMD_WAIT   | wait for irq_i
// CMD_RD     | read CMDR (clears irq), branch on result
// DONE       | done_o pulse
module iicmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int BUS_ID         = 0,
    parameter int LEN_WIDTH      = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_rw_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LEN_WIDTH-1:0]      req_len_i,
    input  logic [7:0]                wdata_i,
    input  logic                      wdata_valid_i,
    output logic                      wdata_ready_o,
    output logic [7:0]                rdata_o,
    output logic                      rdata_valid_o,
    output logic                      done_o,
    output logic [1:0]                status_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);
    import iicmb_pkg::*;

    typedef enum logic [3:0] {
        S_INIT_CSR, S_INIT_DPR, S_INIT_CMD, S_IDLE, S_START, S_ADDR_DPR,
        S_ADDR_CMD, S_WR_GET, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR,
        S_STOP, S_CMD_WAIT, S_CMD_RD, S_DONE
    } state_t;

    // Which command CMD_WAIT/CMD_RD is completing.
    typedef enum logic [2:0] {
        PH_INIT, PH_START, PH_ADDR, PH_WR, PH_RD, PH_STOP
    } phase_t;

    state_t                    state_q, state_d;
    phase_t                    phase_q, phase_d;
    logic                      issued_q, issued_d;
    logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      rw_q, rw_d;
    logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                wbyte_q, wbyte_d;
    status_t                   st_q, st_d;
    logic [7:0]                rdata_q, rdata_d;
    logic                      rdata_valid_q, rdata_valid_d;

    logic                      acc_en, acc_go, acc_we, acc_busy, acc_done;
    logic [WB_ADDR_WIDTH-1:0]  acc_adr;
    logic [WB_DATA_WIDTH-1:0]  acc_dat, acc_rdata;
    logic [LEN_WIDTH-1:0]      cnt_dec;

    assign cnt_dec = (cnt_q != '0) ? cnt_q - LEN_WIDTH'(1) : '0;

    wb_master_access #(
        .ADDR_WIDTH (WB_ADDR_WIDTH),
        .DATA_WIDTH (WB_DATA_WIDTH)
    ) u_wb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .go_i    (acc_go),
        .we_i    (acc_we),
        .adr_i   (acc_adr),
        .wdata_i (acc_dat),
        .busy_o  (acc_busy),
        .done_o  (acc_done),
        .rdata_o (acc_rdata),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= S_INIT_CSR;
            phase_q       <= PH_INIT;
            issued_q      <= 1'b0;
            cnt_q         <= '0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wbyte_q       <= '0;
            st_q          <= ST_OK;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            issued_q      <= issued_d;
            cnt_q         <= cnt_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wbyte_q       <= wbyte_d;
            st_q          <= st_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wbyte_d       = wbyte_q;
        st_d          = st_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        // One access per access-state visit; cleared when it completes.
        issued_d      = acc_go ? 1'b1 : (acc_done ? 1'b0 : issued_q);
        case (state_q)
            S_INIT_CSR: if (acc_done) state_d = S_INIT_DPR;
            S_INIT_DPR: if (acc_done) state_d = S_INIT_CMD;
            S_INIT_CMD: if (acc_done) begin phase_d = PH_INIT;  state_d = S_CMD_WAIT; end
            S_IDLE: begin
                if (req_valid_i) begin
                    rw_d    = req_rw_i;
                    addr_d  = req_addr_i;
                    cnt_d   = req_len_i;
                    st_d    = ST_OK;
                    state_d = S_START;
                end
            end
            S_START:    if (acc_done) begin phase_d = PH_START; state_d = S_CMD_WAIT; end
            S_ADDR_DPR: if (acc_done) state_d = S_ADDR_CMD;
            S_ADDR_CMD: if (acc_done) begin phase_d = PH_ADDR;  state_d = S_CMD_WAIT; end
            S_WR_GET: begin
                if (wdata_valid_i) begin
                    wbyte_d = wdata_i;
                    state_d = S_WR_DPR;
                end
            end
            S_WR_DPR:   if (acc_done) state_d = S_WR_CMD;
            S_WR_CMD:   if (acc_done) begin phase_d = PH_WR;    state_d = S_CMD_WAIT; end
            S_RD_CMD:   if (acc_done) begin phase_d = PH_RD;    state_d = S_CMD_WAIT; end
            S_RD_DPR: begin
                if (acc_done) begin
                    rdata_d       = acc_rdata[7:0];
                    rdata_valid_d = 1'b1;
                    cnt_d         = cnt_dec;
                    state_d       = (cnt_q <= LEN_WIDTH'(1)) ? S_STOP : S_RD_CMD;
                end
            end
            S_STOP:     if (acc_done) begin phase_d = PH_STOP;  state_d = S_CMD_WAIT; end
            S_CMD_WAIT: if (irq_i) state_d = S_CMD_RD;
            S_CMD_RD: begin
                if (acc_done) begin
                    if (phase_q == PH_INIT) begin
                        state_d = (acc_rdata[CMDR_DON] && !acc_rdata[CMDR_AL] &&
                                   !acc_rdata[CMDR_ERR] && !acc_rdata[CMDR_NAK])
                                  ? S_IDLE : S_INIT_CSR;
                    end else if (acc_rdata[CMDR_AL]) begin
                        // Core has already released the bus: no STOP.
                        st_d    = ST_AL;
                        state_d = S_DONE;
                    end else if (acc_rdata[CMDR_ERR]) begin
                        st_d    = ST_ERR;
                        state_d = S_DONE;
                    end else if (acc_rdata[CMDR_NAK] && phase_q != PH_STOP) begin
                        st_d    = ST_NAK;
                        state_d = S_STOP;
                    end else begin
                        case (phase_q)
                            PH_START: state_d = S_ADDR_DPR;
                            PH_ADDR: begin
                                if (cnt_q == '0) state_d = S_STOP;
                                else if (rw_q)   state_d = S_RD_CMD;
                                else             state_d = S_WR_GET;
                            end
                            PH_WR: begin
                                cnt_d   = cnt_dec;
                                state_d = (cnt_q <= LEN_WIDTH'(1)) ? S_STOP : S_WR_GET;
                            end
                            PH_RD:   state_d = S_RD_DPR;
                            default: state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_DONE:  state_d = (st_q == ST_ERR) ? S_INIT_CSR : S_IDLE;
            default: state_d = S_INIT_CSR;
        endcase
    end

    always_comb begin
        acc_en  = 1'b1;
        acc_we  = 1'b1;
        acc_adr = WB_ADDR_WIDTH'(REG_CMDR);
        acc_dat = '0;
        case (state_q)
            S_INIT_CSR: begin acc_adr = WB_ADDR_WIDTH'(REG_CSR); acc_dat = WB_DATA_WIDTH'(CSR_ENABLE); end
            S_INIT_DPR: begin acc_adr = WB_ADDR_WIDTH'(REG_DPR); acc_dat = WB_DATA_WIDTH'(BUS_ID); end
            S_INIT_CMD: acc_dat = WB_DATA_WIDTH'(CMD_SET_BUS);
            S_START:    acc_dat = WB_DATA_WIDTH'(CMD_START);
            S_ADDR_DPR: begin acc_adr = WB_ADDR_WIDTH'(REG_DPR); acc_dat = WB_DATA_WIDTH'({addr_q, rw_q}); end
            S_ADDR_CMD: acc_dat = WB_DATA_WIDTH'(CMD_WRITE);
            S_WR_DPR:   begin acc_adr = WB_ADDR_WIDTH'(REG_DPR); acc_dat = WB_DATA_WIDTH'(wbyte_q); end
            S_WR_CMD:   acc_dat = WB_DATA_WIDTH'(CMD_WRITE);
            S_RD_CMD:   acc_dat = (cnt_q == LEN_WIDTH'(1)) ? WB_DATA_WIDTH'(CMD_READ_NAK)
                                                           : WB_DATA_WIDTH'(CMD_READ_ACK);
            S_RD_DPR:   begin acc_we = 1'b0; acc_adr = WB_ADDR_WIDTH'(REG_DPR); end
            S_STOP:     acc_dat = WB_DATA_WIDTH'(CMD_STOP);
            S_CMD_RD:   acc_we = 1'b0;
            default:    acc_en = 1'b0;
        endcase
        acc_go        = acc_en && !issued_q && !acc_busy;
        req_ready_o   = (state_q == S_IDLE);
        wdata_ready_o = (state_q == S_WR_GET) && wdata_valid_i;
        done_o        = (state_q == S_DONE);
        status_o      = st_q;
        rdata_o       = rdata_q;
        rdata_valid_o = rdata_valid_q;
    end

endmodule

// File: tb/tb_iicmb_wb_sequencer.sv
`timescale 1ns/1ps
module tb_iicmb_wb_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic       req_rw_i = 1'b0;
    logic [6:0] req_addr_i = '0;
    logic [5:0] req_len_i = '0;
    logic [7:0] wdata_i = '0;
    logic       wdata_valid_i = 1'b0;
    logic       wdata_ready_o;
    logic [7:0] rdata_o;
    logic       rdata_valid_o;
    logic       done_o;
    logic [1:0] status_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i = '0;
    logic       ack_i = 1'b0;
    logic       irq_i = 1'b0;

    iicmb_wb_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .done_o(done_o), .status_o(status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected Wishbone writes {adr, dat}, and expected output events:
    // {0, byte} for a read byte, {1, 000000, status} for done.
    logic [9:0] exp_wb[$];
    logic [8:0] exp_out[$];
    logic [7:0] dq[$];
    logic [7:0] tb_rd_seq = 8'h64;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- IICMB core + I2C bus model ----------------
    // One slave at 0x22 that acks everything and returns an incrementing
    // byte sequence starting at 0x64; any other address NAKs.
    int         ws_cnt = 0;
    int         m_timer = 0;
    int         m_inj = 0;           // 1: next WRITE/READ command loses arbitration, 2: errors
    int         wb_wr_cnt = 0;
    logic [2:0] m_cmd = '0;
    logic [7:0] m_dpr_w = '0, m_dpr_r = '0, m_cmdr = '0, m_rd_seq = 8'h64;
    bit         m_expect_addr = 0;

    always @(negedge clk_i) begin
        logic [9:0] e;
        logic [7:0] st;
        if (!rst_i) begin
            ack_i = 1'b0; irq_i = 1'b0; dat_i = '0; ws_cnt = 0; m_timer = 0;
            m_rd_seq = 8'h64; m_expect_addr = 0; m_cmdr = '0; m_dpr_r = '0; m_dpr_w = '0;
        end else begin
            if (ack_i) begin
                ack_i = 1'b0;
            end else if (cyc_o && stb_o) begin
                if (ws_cnt > 0) ws_cnt--;
                else begin
                    ack_i  = 1'b1;
                    ws_cnt = $urandom_range(0, 2);
                    if (we_o) begin
                        wb_wr_cnt++;
                        check_eq("wb_write_expected", 32'(exp_wb.size() != 0), 1);
                        if (exp_wb.size() != 0) begin
                            e = exp_wb.pop_front();
                            check_eq("wb_write", {adr_o, dat_o}, e);
                        end
                        if (adr_o == 2'd2) begin
                            m_cmd   = dat_o[2:0];
                            m_timer = $urandom_range(1, 5);
                            irq_i   = 1'b0;
                        end else if (adr_o == 2'd1) begin
                            m_dpr_w = dat_o;
                        end
                    end else begin
                        case (adr_o)
                            2'd2:    begin dat_i = m_cmdr; irq_i = 1'b0; end
                            2'd1:    dat_i = m_dpr_r;
                            default: dat_i = '0;
                        endcase
                    end
                end
            end
            if (m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) begin
                    st = 8'h80;
                    if (m_inj != 0 && (m_cmd == 3'd1 || m_cmd == 3'd2 || m_cmd == 3'd3)) begin
                        st = (m_inj == 1) ? 8'h20 : 8'h10;
                        m_inj = 0;
                        m_expect_addr = 0;
                    end else if (m_cmd == 3'd4) begin
                        m_expect_addr = 1;
                    end else if (m_cmd == 3'd1 && m_expect_addr) begin
                        m_expect_addr = 0;
                        if (m_dpr_w[7:1] != 7'h22) st = 8'h40;
                    end else if (m_cmd == 3'd2 || m_cmd == 3'd3) begin
                        m_dpr_r  = m_rd_seq;
                        m_rd_seq = m_rd_seq + 8'd1;
                    end
                    m_cmdr = st | {5'd0, m_cmd};
                    irq_i  = 1'b1;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    always @(negedge clk_i) begin
        logic [8:0] e;
        if (rst_i) begin
            if (rdata_valid_o) begin
                check_eq("rdata_expected", 32'(exp_out.size() != 0), 1);
                if (exp_out.size() != 0) begin
                    e = exp_out.pop_front();
                    check_eq("rdata", {1'b0, rdata_o}, e);
                end
            end
            if (done_o) begin
                check_eq("done_expected", 32'(exp_out.size() != 0), 1);
                if (exp_out.size() != 0) begin
                    e = exp_out.pop_front();
                    check_eq("done_status", {1'b1, 6'd0, status_o}, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_wb(input logic [1:0] a, input logic [7:0] d);
        exp_wb.push_back({a, d});
    endtask

    task automatic push_init();
        push_wb(2'd0, 8'hC0);
        push_wb(2'd1, 8'h00);
        push_wb(2'd2, 8'h06);
    endtask

    task automatic check_outputs_zero(input string name);
        check_eq(name, {cyc_o, stb_o, we_o, req_ready_o, done_o, rdata_valid_o, wdata_ready_o,
                        adr_o, dat_o, status_o, rdata_o}, 0);
    endtask

    task automatic wait_ready(input string name);
        for (int k = 0; k < 3000 && !req_ready_o; k++) begin
            @(posedge clk_i); #1;
        end
        check_eq(name, 32'(req_ready_o), 1);
    endtask

    // Reset is asserted at posedge+1 by the caller; hold it and re-arm expectations.
    task automatic finish_reset();
        exp_wb.delete();
        exp_out.delete();
        tb_rd_seq = 8'h64;
        repeat (3) begin @(posedge clk_i); #1; end
        check_outputs_zero("reset_hold_outputs");
        push_init();
        rst_i = 1'b1;
        wait_ready("init_ready");
    endtask

    task automatic run_txn(input bit rw, input logic [6:0] addr, input int len,
                           input int inj, input int stall, input bit rst_mid);
        logic [7:0] bytes[$];
        logic [1:0] exp_st;
        int exp_cons = 0, idx = 0, cons = 0, stall_left = stall, start_cnt;
        bit seen_done = 0, got_rd = 0, rst_hit = 0, hs;
        for (int i = 0; i < len; i++)
            bytes.push_back((i < dq.size()) ? dq[i] : 8'($urandom));
        dq.delete();

        push_wb(2'd2, 8'h04);
        push_wb(2'd1, {addr, rw});
        push_wb(2'd2, 8'h01);
        if (inj == 1) exp_st = 2'b10;
        else if (inj == 2) begin exp_st = 2'b11; push_init(); end
        else if (addr != 7'h22) begin exp_st = 2'b01; push_wb(2'd2, 8'h05); end
        else begin
            exp_st = 2'b00;
            for (int i = 0; i < len; i++) begin
                if (!rw) begin
                    push_wb(2'd1, bytes[i]);
                    push_wb(2'd2, 8'h01);
                end else begin
                    push_wb(2'd2, (i == len - 1) ? 8'h03 : 8'h02);
                    exp_out.push_back({1'b0, tb_rd_seq});
                    tb_rd_seq = tb_rd_seq + 8'd1;
                end
            end
            if (!rw) exp_cons = len;
            push_wb(2'd2, 8'h05);
        end
        exp_out.push_back({1'b1, 6'd0, exp_st});

        wait_ready("ready_before_req");
        m_inj       = inj;
        req_rw_i    = rw;
        req_addr_i  = addr;
        req_len_i   = 6'(len);
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check_eq("ready_drops_after_accept", 32'(req_ready_o), 0);
        start_cnt = wb_wr_cnt;

        for (int c = 0; c < 20000 && !seen_done; c++) begin
            if (rst_mid && got_rd && stb_o && !we_o) begin
                rst_hit = 1;
                break;
            end
            if (stall_left > 0) begin
                wdata_valid_i = 1'b0;
                stall_left--;
                if (stall_left == 0)
                    check_eq("stall_no_cmd_writes", wb_wr_cnt - start_cnt, 3);
            end else begin
                wdata_valid_i = (idx < len) && !rw;
                wdata_i       = (idx < len) ? bytes[idx] : 8'h00;
            end
            @(negedge clk_i);
            hs = wdata_valid_i && wdata_ready_o;
            if (done_o) seen_done = 1;
            if (rdata_valid_o) got_rd = 1;
            @(posedge clk_i); #1;
            if (hs) begin idx++; cons++; end
        end
        wdata_valid_i = 1'b0;

        if (rst_mid) begin
            rst_i = 1'b0;
            check_eq("reset_mid_read_reached", 32'(rst_hit), 1);
            check_eq("no_done_before_reset", 32'(seen_done), 0);
            @(posedge clk_i); #1;
            check_outputs_zero("reset_bus_drop");
            finish_reset();
        end else begin
            check_eq("done_seen", 32'(seen_done), 1);
            check_eq("bytes_consumed", cons, exp_cons);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) begin @(posedge clk_i); #1; end
        check_outputs_zero("reset_outputs");
        finish_reset();

        dq = '{8'hAA, 8'hBB, 8'hCC};
        run_txn(1'b0, 7'h22, 3, 0, 0, 0);          // write 3 bytes
        run_txn(1'b1, 7'h22, 4, 0, 0, 0);          // read 64..67
        run_txn(1'b0, 7'h10, 2, 0, 0, 0);          // absent slave
        run_txn(1'b0, 7'h22, 2, 0, 200, 0);        // write stream stalls
        run_txn(1'b0, 7'h22, 0, 0, 0, 0);          // address-only probe
        run_txn(1'b1, 7'h22, 1, 0, 0, 0);          // single read byte
        run_txn(1'b1, 7'h10, 3, 0, 0, 0);          // read from absent slave
        run_txn(1'b0, 7'h22, 63, 0, 0, 0);         // maximum length
        run_txn(1'b0, 7'h22, 2, 1, 0, 0);          // arbitration lost
        run_txn(1'b1, 7'h22, 2, 2, 0, 0);          // core error, re-init
        for (int t = 0; t < 20; t++)
            run_txn(1'($urandom), ($urandom_range(0, 3) == 0) ? 7'h10 : 7'h22,
                    $urandom_range(0, 5), 0, 0, 0);
        run_txn(1'b1, 7'h22, 4, 0, 0, 1);          // reset mid-read
        run_txn(1'b0, 7'h22, 0, 0, 0, 0);          // probe after reset

        repeat (10) begin @(posedge clk_i); #1; end
        check_eq("wb_queue_drained", exp_wb.size(), 0);
        check_eq("out_queue_drained", exp_out.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iicmb_wb_sequencer.md
Name: iicmb_wb_sequencer

Overview:
Hardware Wishbone master that sequences the IICMB I2C multi-bus controller (iicmb_m_wb) in place of software. It brings the core up, then runs each requested I2C write or read transaction as the full CMDR/DPR command chain: start, address, data bytes, stop. It sits between a simple request/byte-stream interface and the IICMB Wishbone slave port, and uses the core's irq to detect command completion.

Parameters:
WB_ADDR_WIDTH, 2, Wishbone address width (IICMB register select)
WB_DATA_WIDTH, 8, Wishbone data width
I2C_ADDR_WIDTH, 7, I2C slave address width
BUS_ID, 0, IICMB bus number written to DPR before the Set Bus command
LEN_WIDTH, 6, width of req_len; maximum transfer is 2**LEN_WIDTH-1 bytes

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  reset, synchronous, active-low
req_valid_i  in  1  transaction request valid
req_ready_o  out  1  sequencer idle and initialised; request accepted when valid&&ready
req_rw_i  in  1  1=I2C read, 0=I2C write
req_addr_i  in  I2C_ADDR_WIDTH  I2C slave address
req_len_i  in  LEN_WIDTH  byte count; 0 = address-only probe
wdata_i  in  8  write byte
wdata_valid_i  in  1  write byte valid
wdata_ready_o  out  1  write byte consumed this cycle
rdata_o  out  8  read byte
rdata_valid_o  out  1  one-cycle pulse per read byte; no backpressure
done_o  out  1  one-cycle pulse at transaction end
status_o  out  2  valid with done_o: 00 ok, 01 NAK, 10 arbitration lost, 11 error
cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
adr_o  out  WB_ADDR_WIDTH  register select: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR
dat_o  out  WB_DATA_WIDTH  write data
dat_i  in  WB_DATA_WIDTH  read data
ack_i  in  1  Wishbone acknowledge
irq_i  in  1  IICMB interrupt, level

Behaviour:
- Reset (rst_i low at a clock edge): all outputs 0 on the next edge, including cyc_o/stb_o mid-cycle. Any in-flight transaction is dropped with no done_o. State returns to INIT.
- Wishbone access: cyc_o, stb_o, we_o, adr_o and dat_o are registered and held until ack_i is sampled high, then all deasserted on the next edge. Read data is captured on ack. Minimum 2 cycles per access. No back-to-back accesses without a one-cycle idle.
- INIT sequence: write CSR=0xC0 (enable + IE), write DPR=BUS_ID, write CMDR=0x06. Then wait for irq_i high and read CMDR. DON (bit7) set -> IDLE with req_ready_o=1; ERR (bit4) set -> retry INIT.
- Command completion (CMD_WAIT): wait for irq_i==1, then read CMDR (the read clears irq). Evaluate DON, NAK (bit6), AL (bit5), ERR (bit4), in priority AL > ERR > NAK > DON.
- Transaction sequence:
  - START: CMDR=0x04, wait.
  - ADDR: DPR={addr,rw}, CMDR=0x01, wait.
  - Write path, req_len bytes: assert wdata_ready_o for exactly one cycle when wdata_valid_i is high, latch the byte, DPR=byte, CMDR=0x01, wait. Stalls indefinitely while wdata_valid_i is low.
  - Read path: bytes 1..len-1 use CMDR=0x02 (read + ACK); the last byte uses 0x03 (read + NAK). Each: wait, then read DPR and pulse rdata_valid_o with the byte.
  - STOP: CMDR=0x05, wait; done_o=1 with status 00.
- NAK on the address or a write byte: skip remaining bytes, issue STOP, status 01.
- AL: no STOP (the core has already released the bus); done_o with status 10 immediately.
- ERR: done_o with status 11, then re-run INIT.
- req_len=0: START, ADDR, STOP only.
- A request accepted on the same cycle as done_o is impossible; req_ready_o is low until the cycle after done_o.
- Byte counter: LEN_WIDTH bits, counts down, no wrap.

Decomposition:
- Package iicmb_pkg: register address constants (CSR/DPR/CMDR/FSMR), CMDR command codes (START 100, STOP 101, READ_ACK 010, READ_NAK 011, WRITE 001, SET_BUS 110), CMDR status bit indices, CSR enable value 0xC0, status_t enum.
- Sub-module wb_master_access: single-access Wishbone engine with go/we/adr/wdata in and busy/done/rdata out. The top-level FSM sequences calls to it.

Test Plan:
- Reset release, IICMB slave model -> observe writes CSR=C0, DPR=00, CMDR=06, then a CMDR read; req_ready_o rises afterwards.
- Write addr 0x22, len 3, bytes AA,BB,CC -> I2C monitor sees write to 0x22 with data AA,BB,CC; done_o with status 00; DPR sees 0x44 first.
- Read addr 0x22, len 4, slave supplies 64..67 -> rdata_valid_o pulses 4 times with 64,65,66,67; last command 0x03; status 00.
- Write to an absent address 0x10, len 2 -> NAK after address, STOP issued, no wdata_ready_o, status 01.
- Write len 2 with wdata_valid_i held low 200 cycles -> bus stalls with no CMDR write; resumes when valid rises.
- Assert rst_i low while stb_o is high mid-read -> cyc_o/stb_o 0 next edge, no done_o, INIT repeats; next len 0 probe of 0x22 gives status 00.
